// File: rtl/fm_sched_pkg.sv
// Shared types, config encodings and saturation helper for the FM operator scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fm_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [1:0] CFG_MODSRC   = 2'd0;
  localparam logic [1:0] CFG_MODSHIFT = 2'd1;
  localparam logic [1:0] CFG_CARRIER  = 2'd2;

  // Clamp a signed value to the signed range of a 'width'-bit word. Works on a
  // 64-bit container so any accumulator up to 64 bits can be passed in; the
  // caller truncates the result to 'width' bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] acc,
                                                    input int unsigned       width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (acc > max_v) return max_v;
    if (acc < min_v) return min_v;
    return acc;
  endfunction

endpackage

// File: rtl/fm_sched_cfg_regs.sv
// Per-operator modulation source/shift registers plus the carrier mask, with write decode.
// Latency: a write is visible on the read ports the cycle after cfgWe.
// Backpressure: none; writes are always accepted.
// Ports: cfgWe/cfgSel/cfgAddr/cfgData write side; rdOp selects the operator
// whose modSrc/modShift are presented; carrierMask is presented whole.
module fm_sched_cfg_regs
  import fm_sched_pkg::*;
#(
  parameter int NUM_OPS = 8,
  parameter int OP_W    = $clog2(NUM_OPS)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               cfgWe,
  input  logic [1:0]         cfgSel,
  input  logic [OP_W-1:0]    cfgAddr,
  input  logic [31:0]        cfgData,
  input  logic [OP_W-1:0]    rdOp,
  output logic [OP_W:0]      modSrc,
  output logic [4:0]         modShift,
  output logic [NUM_OPS-1:0] carrierMask
);

  logic [OP_W:0] mod_src_q   [NUM_OPS];
  logic [4:0]    mod_shift_q [NUM_OPS];

  // Only the low bits of cfgData matter for any register.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^cfgData;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < NUM_OPS; k++) begin
        mod_src_q[k]   <= (OP_W+1)'(NUM_OPS);  // out of range = unmodulated
        mod_shift_q[k] <= '0;
      end
      carrierMask <= NUM_OPS'(1);
    end else if (cfgWe) begin
      case (cfgSel)
        CFG_MODSRC:   mod_src_q[cfgAddr]   <= cfgData[OP_W:0];
        CFG_MODSHIFT: mod_shift_q[cfgAddr] <= cfgData[4:0];
        CFG_CARRIER:  carrierMask          <= cfgData[NUM_OPS-1:0];
        default: ;
      endcase
    end
  end

  assign modSrc   = mod_src_q[rdOp];
  assign modShift = mod_shift_q[rdOp];

endmodule

// File: rtl/fm_operator_scheduler.sv
// Sequences one sample round across NUM_OPS oscillators with FM routing and a saturated carrier mix.
// Latency: mixValid NUM_OPS*(PIPE_LAT+1)+1 cycles after sampleTick.
// Backpressure: none; a sampleTick while busy is dropped and flagged on overrun.
// Ports: sampleTick starts a round; cfg* writes routing/mask; oscSig is the
// packed operator outputs; oscEn/fOffset drive the operators; mixOut/mixValid
// carry the result; busy and overrun report round status.
module fm_operator_scheduler
  import fm_sched_pkg::*;
#(
  parameter int NUM_OPS  = 8,
  parameter int OP_W     = $clog2(NUM_OPS),
  parameter int P_WIDTH  = 32,
  parameter int SIG_W    = 32,
  parameter int PIPE_LAT = 4
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     sampleTick,
  input  logic                     cfgWe,
  input  logic [1:0]               cfgSel,
  input  logic [OP_W-1:0]          cfgAddr,
  input  logic [31:0]              cfgData,
  input  logic [NUM_OPS*SIG_W-1:0] oscSig,
  output logic [NUM_OPS-1:0]       oscEn,
  output logic [P_WIDTH-1:0]       fOffset,
  output logic [SIG_W-1:0]         mixOut,
  output logic                     mixValid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int              ACC_W   = SIG_W + OP_W + 1;
  localparam int              CNT_W   = $clog2(PIPE_LAT + 1);
  localparam logic [OP_W-1:0] LAST_OP = OP_W'(NUM_OPS - 1);

  state_t                    state, state_nxt;
  logic [OP_W-1:0]           op;
  logic [CNT_W-1:0]          cnt;
  logic signed [ACC_W-1:0]   acc, acc_nxt;
  logic signed [SIG_W-1:0]   op_out [NUM_OPS];
  logic signed [SIG_W-1:0]   cur_sig, src_sig;
  logic signed [P_WIDTH-1:0] src_ext;
  logic [P_WIDTH-1:0]        foff_q, foff_issue;
  logic [OP_W:0]             mod_src;
  logic [4:0]                mod_shift;
  logic [NUM_OPS-1:0]        carrier_mask;

  fm_sched_cfg_regs #(
    .NUM_OPS (NUM_OPS),
    .OP_W    (OP_W)
  ) u_cfg (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .cfgWe       (cfgWe),
    .cfgSel      (cfgSel),
    .cfgAddr     (cfgAddr),
    .cfgData     (cfgData),
    .rdOp        (op),
    .modSrc      (mod_src),
    .modShift    (mod_shift),
    .carrierMask (carrier_mask)
  );

  // FM offset for the operator being issued. op_out holds this round's value
  // for lower-indexed sources and last round's for the rest, which is exactly
  // the serial-chain / feedback ordering we want. NUM_OPS is a power of two,
  // so the MSB of mod_src alone marks "no source".
  always_comb begin
    src_sig    = op_out[mod_src[OP_W-1:0]];
    src_ext    = P_WIDTH'(src_sig);
    foff_issue = '0;
    if (!mod_src[OP_W]) foff_issue = src_ext >>> mod_shift;
  end

  assign cur_sig = oscSig[op*SIG_W +: SIG_W];
  assign acc_nxt = carrier_mask[op] ? acc + ACC_W'(cur_sig) : acc;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    oscEn     = '0;
    fOffset   = foff_q;
    busy      = (state != IDLE);
    mixValid  = 1'b0;
    case (state)
      IDLE:    if (sampleTick) state_nxt = ISSUE;
      ISSUE: begin
        oscEn[op] = 1'b1;
        fOffset   = foff_issue;
        state_nxt = WAIT;
      end
      WAIT:    if (cnt == CNT_W'(PIPE_LAT - 1)) state_nxt = CAPTURE;
      CAPTURE: state_nxt = (op == LAST_OP) ? DONE : ISSUE;
      DONE: begin
        mixValid  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      op      <= '0;
      cnt     <= '0;
      acc     <= '0;
      foff_q  <= '0;
      mixOut  <= '0;
      overrun <= 1'b0;
      for (int k = 0; k < NUM_OPS; k++) op_out[k] <= '0;
    end else begin
      overrun <= sampleTick && busy;
      case (state)
        IDLE: if (sampleTick) begin
          op  <= '0;
          acc <= '0;
        end
        ISSUE: begin
          foff_q <= foff_issue;
          cnt    <= CNT_W'(1);
        end
        WAIT: cnt <= cnt + CNT_W'(1);
        CAPTURE: begin
          op_out[op] <= cur_sig;
          acc        <= acc_nxt;
          // mixOut is loaded here so it is already stable in the DONE cycle
          // that raises mixValid.
          if (op == LAST_OP) mixOut <= SIG_W'(sat_signed(64'(acc_nxt), SIG_W));
          else               op     <= op + OP_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fm_operator_scheduler.sv
module tb_fm_operator_scheduler;

  typedef logic [31:0] w8_t [8];
  typedef struct { int cyc; int op; logic [31:0] foff; } iss_t;
  typedef struct { int cyc; logic [31:0] val; } mix_t;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         sampleTick = 1'b0;
  logic         cfgWe = 1'b0;
  logic [1:0]   cfgSel = '0;
  logic [2:0]   cfgAddr = '0;
  logic [31:0]  cfgData = '0;
  logic [255:0] oscSig;
  logic [7:0]   oscEn;
  logic [31:0]  fOffset;
  logic [31:0]  mixOut;
  logic         mixValid;
  logic         busy;
  logic         overrun;

  logic [31:0] sig_v [8];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  iss_t iss_q[$];
  mix_t mix_q[$];
  int   ov_q[$];

  bit          hold_act = 0;
  int          hold_cyc = 0;
  logic [31:0] hold_val = '0;

  fm_operator_scheduler dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .sampleTick (sampleTick),
    .cfgWe      (cfgWe),
    .cfgSel     (cfgSel),
    .cfgAddr    (cfgAddr),
    .cfgData    (cfgData),
    .oscSig     (oscSig),
    .oscEn      (oscEn),
    .fOffset    (fOffset),
    .mixOut     (mixOut),
    .mixValid   (mixValid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc = cyc + 1;

  always_comb begin
    oscSig = '0;
    for (int k = 0; k < 8; k++) oscSig[k*32 +: 32] = sig_v[k];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=unexpected output required=none (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents an output.
  always @(negedge Clk) begin
    if (hold_act && cyc == hold_cyc) begin
      hold_act = 0;
      check("foff_hold_wait", 64'(fOffset), 64'(hold_val));
    end
    if (oscEn != 8'h00) begin
      if (iss_q.size() == 0) unexpected("issue");
      else begin
        iss_t e;
        e = iss_q.pop_front();
        check("issue_cycle", 64'(cyc), 64'(e.cyc));
        check("issue_onehot", 64'(oscEn), 64'(8'h01 << e.op));
        check("issue_foff", 64'(fOffset), 64'(e.foff));
        hold_act = 1;
        hold_cyc = cyc + 3;
        hold_val = e.foff;
      end
    end
    if (mixValid) begin
      if (mix_q.size() == 0) unexpected("mix");
      else begin
        mix_t m;
        m = mix_q.pop_front();
        check("mix_cycle", 64'(cyc), 64'(m.cyc));
        check("mix_out", 64'(mixOut), 64'(m.val));
      end
    end
    if (overrun) begin
      if (ov_q.size() == 0) unexpected("overrun");
      else check("overrun_cycle", 64'(cyc), 64'(ov_q.pop_front()));
    end
  end

  task automatic do_reset();
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [2:0] addr, input logic [31:0] d);
    @(posedge Clk); #1;
    cfgWe = 1'b1; cfgSel = sel; cfgAddr = addr; cfgData = d;
    @(posedge Clk); #1;
    cfgWe = 1'b0;
  endtask

  task automatic set_all(input logic [31:0] v);
    for (int k = 0; k < 8; k++) sig_v[k] = v;
  endtask

  task automatic set_ramp();
    for (int k = 0; k < 8; k++) sig_v[k] = 32'(k + 100);
  endtask

  // Fires one tick and queues the expected issues and mix. Returns at cycle t0+1.
  task automatic do_round(input w8_t foff, input logic [31:0] mix, input int n_iss, input bit has_mix);
    int t0;
    @(posedge Clk); #1;
    sampleTick = 1'b1;
    t0 = cyc;
    for (int k = 0; k < n_iss; k++) iss_q.push_back('{t0 + 1 + 5*k, k, foff[k]});
    if (has_mix) mix_q.push_back('{t0 + 41, mix});
    @(posedge Clk); #1;
    sampleTick = 1'b0;
  endtask

  initial begin
    w8_t zf, f;
    for (int k = 0; k < 8; k++) zf[k] = '0;
    set_ramp();

    // Reset then idle
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (20) @(posedge Clk);
    #1;
    check("rst_oscEn", 64'(oscEn), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_mixOut", 64'(mixOut), 64'h0);
    check("rst_mixValid", 64'(mixValid), 64'h0);
    check("rst_fOffset", 64'(fOffset), 64'h0);
    check("rst_overrun", 64'(overrun), 64'h0);

    // Single round, defaults: only op0 (100) is a carrier
    do_round(zf, 32'd100, 8, 1);
    #1 check("busy_in_round", 64'(busy), 64'h1);
    repeat (45) @(posedge Clk);
    #1 check("idle_after_round", 64'(busy), 64'h0);

    // FM routing: op1 modulated by this round's op0 (-64 >>> 2 = -16)
    cfg(2'd0, 3'd1, 32'd0);
    cfg(2'd1, 3'd1, 32'd2);
    sig_v[0] = 32'hFFFF_FFC0;
    f = zf; f[1] = 32'hFFFF_FFF0;
    do_round(f, 32'hFFFF_FFC0, 8, 1);
    repeat (45) @(posedge Clk);

    // Self-feedback on op2, and a shift write landing on op2's ISSUE cycle
    do_reset();
    set_ramp();
    sig_v[2] = 32'd7;
    cfg(2'd0, 3'd2, 32'd2);
    do_round(zf, 32'd100, 8, 1);
    repeat (45) @(posedge Clk);
    f = zf; f[2] = 32'd7;
    do_round(f, 32'd100, 8, 1);
    repeat (10) @(posedge Clk);
    #1; cfgWe = 1'b1; cfgSel = 2'd1; cfgAddr = 3'd2; cfgData = 32'd1;
    @(posedge Clk); #1 cfgWe = 1'b0;
    repeat (40) @(posedge Clk);
    f = zf; f[2] = 32'd3;
    do_round(f, 32'd100, 8, 1);
    repeat (45) @(posedge Clk);

    // Saturation and signed sum
    do_reset();
    cfg(2'd2, 3'd0, 32'hFF);
    set_all(32'h7FFF_FFFF);
    do_round(zf, 32'h7FFF_FFFF, 8, 1);
    repeat (45) @(posedge Clk);
    set_all(32'h8000_0000);
    do_round(zf, 32'h8000_0000, 8, 1);
    repeat (45) @(posedge Clk);
    cfg(2'd2, 3'd5, 32'h0A);
    sig_v[1] = 32'd1000;
    sig_v[3] = 32'hFFFF_F448;
    do_round(zf, 32'hFFFF_F830, 8, 1);
    repeat (45) @(posedge Clk);

    // Overrun mid-round and on the DONE cycle
    do_reset();
    set_ramp();
    do_round(zf, 32'd100, 8, 1);
    repeat (9) @(posedge Clk);
    #1 sampleTick = 1'b1;
    ov_q.push_back(cyc + 1);
    @(posedge Clk); #1 sampleTick = 1'b0;
    repeat (30) @(posedge Clk);
    #1 sampleTick = 1'b1;
    ov_q.push_back(cyc + 1);
    @(posedge Clk); #1 sampleTick = 1'b0;
    repeat (50) @(posedge Clk);

    // Reset mid-round aborts it with no mix
    do_round(zf, 32'd0, 4, 0);
    repeat (19) @(posedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    check("abort_oscEn", 64'(oscEn), 64'h0);
    check("abort_busy", 64'(busy), 64'h0);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (60) @(posedge Clk);
    #1;

    check("iss_q_empty", 64'(iss_q.size()), 64'h0);
    check("mix_q_empty", 64'(mix_q.size()), 64'h0);
    check("ov_q_empty", 64'(ov_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fm_operator_scheduler.md
Name: fm_operator_scheduler

Overview:
- Sequences one audio sample's evaluation across NUM_OPS parallel direct-digital oscillator operators in the FM matrix.
- On each sample tick, enables operators one at a time in index order. Each operator gets a phase-modulation offset taken from a selectable source operator's most recent output.
- Captures each operator's signal after the oscillator pipeline latency, then sums the carrier-flagged operators into a saturated mix sample.

Parameters:
- NUM_OPS, 8, number of operators (power of two, ≥2)
- OP_W, $clog2(NUM_OPS), operator index width
- P_WIDTH, 32, phasor / FM offset width
- SIG_W, 32, oscillator sigOut width (signed)
- PIPE_LAT, 4, cycles from oscEn pulse to valid oscSig (≥2)

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- sampleTick  in  1  one-cycle pulse: start a sample round
- cfgWe  in  1  config write strobe
- cfgSel  in  2  0=modSrc, 1=modShift, 2=carrierMask, 3=reserved (ignored)
- cfgAddr  in  OP_W  target operator (ignored for carrierMask)
- cfgData  in  32  write data (LSBs used)
- oscSig  in  NUM_OPS*SIG_W  packed sigOut of all operators, op k at [k*SIG_W +: SIG_W]
- oscEn  out  NUM_OPS  one-hot enable, one cycle per operator per round
- fOffset  out  P_WIDTH  FM offset for the currently enabled operator
- mixOut  out  SIG_W  saturated carrier sum (signed)
- mixValid  out  1  one-cycle pulse when mixOut updates
- busy  out  1  round in progress
- overrun  out  1  one-cycle pulse: sampleTick dropped

Behaviour:
- Reset values (async, Reset_n=0): FSM IDLE; oscEn, fOffset, mixOut, mixValid, busy, overrun all 0; opOut[k]=0; modSrc[k]=NUM_OPS (none); modShift[k]=0; carrierMask=1 (op0 only). Reset mid-round aborts it immediately, with no mixValid.
- Config registers:
  - modSrc[k]: OP_W+1 bits. Values ≥NUM_OPS mean no modulation.
  - modShift[k]: 5 bits.
  - carrierMask: NUM_OPS bits.
  - Writes are accepted in any state and take effect next cycle. An operator's settings are sampled at its ISSUE cycle.
- FSM states and transitions:
  - IDLE: on sampleTick, go to ISSUE with op=0 and acc=0.
  - ISSUE (1 cycle):
    - oscEn[op]=1.
    - fOffset = sign-extended opOut[modSrc[op]] >>> modShift[op] (arithmetic), or 0 if no source.
    - Cnt=1. Go to WAIT.
  - WAIT: oscEn=0; fOffset holds. Increment cnt until cnt==PIPE_LAT, then go to CAPTURE.
  - CAPTURE (the cycle PIPE_LAT after ISSUE):
    - opOut[op] <= oscSig[op].
    - If carrierMask[op], acc += oscSig[op]. The accumulator is SIG_W+OP_W+1 bits, signed.
    - If op==NUM_OPS-1 go to DONE; otherwise op++ and go to ISSUE.
  - DONE: mixOut <= acc saturated to SIG_W signed range; mixValid=1; go to IDLE.
- Ordering and feedback:
  - A source index lower than op yields the current-round output, giving serial FM chains.
  - A source ≥op, including self-feedback, yields the previous round's output.
- Latency: mixValid is asserted NUM_OPS*(PIPE_LAT+1)+1 cycles after the sampleTick cycle (41 with defaults).
- busy=1 in every state except IDLE.
- overrun: pulses the cycle after a sampleTick arrives while busy. That tick is discarded and the round in progress continues unaffected.
- A sampleTick coinciding with DONE counts as an overrun (busy=1).
- A cfgWe to an operator in the same cycle as that operator's ISSUE is not seen by that issue; it applies next round.

Decomposition:
- Shared package fm_sched_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, CAPTURE, DONE}
  - cfgSel encodings CFG_MODSRC / CFG_MODSHIFT / CFG_CARRIER
  - a saturation function sat_signed(acc) → SIG_W
- One sub-module, fm_sched_cfg_regs, holds the modSrc, modShift and carrierMask register file and its write decode.
- The FSM, operator output store and accumulator stay in the top.

Test Plan:
- Reset then idle: no sampleTick → oscEn=0, busy=0, mixOut=0, mixValid never asserted.
- Single round, defaults, oscSig[k]=k+100:
  - oscEn[k] is high at cycle 1+5k.
  - fOffset=0 throughout.
  - mixValid at cycle 41 with mixOut=100.
- FM routing: modSrc[1]=0, modShift[1]=2, oscSig[0]=-64 → in round 1, fOffset=0xFFFFFFF0 during op1's ISSUE/WAIT.
- Self-feedback: modSrc[2]=2, modShift=0, oscSig[2]=7 → round 1 fOffset=0 at op2, round 2 fOffset=7.
- Saturation: carrierMask=0xFF, all oscSig=0x7FFFFFFF → mixOut=0x7FFFFFFF. All oscSig=0x80000000 → mixOut=0x80000000.
- Overrun and abort:
  - sampleTick at cycle 10 of a round → overrun pulses at cycle 11 and mixValid stays at cycle 41.
  - Reset_n low at cycle 20 → oscEn=0, busy=0 immediately, and no mixValid follows.
